// File: rtl/cmd_byte_tx.sv
// cmd_byte_tx: serializes one control command per request into the byte
// stream consumed by the sequencing control unit.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   req_valid / req_ready         request handshake (ready only when idle)
//   req_command                   command byte, sent verbatim as byte 0
//   req_block, req_reg            block / register numbers (zero-extended to a byte)
//   req_data, req_instr, req_delay  multi-byte fields, sent MSB first
//   out_byte / out_valid / next   byte stream towards the control unit
//   busy                          frame in progress
//   done, invalid, timeout        one-cycle status pulses
//
// Configuration
//   CMD_BYTE_TX_TIMEOUT_EN   when defined, a frame whose consumer stops
//                            strobing `next` for timeout_cycles is aborted.
//   BLOCK_INSTR_WIDTH, BLOCK_REG_ADDR_WIDTH and the COMMAND_* codes come from
//   the surrounding project; local defaults are provided when absent.
`timescale 1ns/1ps

`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 32
`endif
`ifndef BLOCK_REG_ADDR_WIDTH
`define BLOCK_REG_ADDR_WIDTH 4
`endif
`ifndef COMMAND_WRITE_BLOCK_INSTR
`define COMMAND_WRITE_BLOCK_INSTR 8'h01
`endif
`ifndef COMMAND_WRITE_BLOCK_REG
`define COMMAND_WRITE_BLOCK_REG 8'h02
`endif
`ifndef COMMAND_UPDATE_BLOCK_REG
`define COMMAND_UPDATE_BLOCK_REG 8'h03
`endif
`ifndef COMMAND_ALLOC_SRAM_DELAY
`define COMMAND_ALLOC_SRAM_DELAY 8'h04
`endif
`ifndef COMMAND_SET_INPUT_GAIN
`define COMMAND_SET_INPUT_GAIN 8'h05
`endif
`ifndef COMMAND_SET_OUTPUT_GAIN
`define COMMAND_SET_OUTPUT_GAIN 8'h06
`endif
`ifndef COMMAND_SWAP_PIPELINES
`define COMMAND_SWAP_PIPELINES 8'h07
`endif
`ifndef COMMAND_RESET_PIPELINE
`define COMMAND_RESET_PIPELINE 8'h08
`endif

module cmd_byte_tx #(
    parameter int n_blocks       = 32,
    parameter int data_width     = 16,
    parameter int instr_width    = `BLOCK_INSTR_WIDTH,
    parameter int timeout_cycles = 1023
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_command,
    input  logic [$clog2(n_blocks)-1:0]   req_block,
    input  logic [`BLOCK_REG_ADDR_WIDTH-1:0] req_reg,
    input  logic [data_width-1:0]         req_data,
    input  logic [instr_width-1:0]        req_instr,
    input  logic [2*data_width-1:0]       req_delay,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          next,
    output logic                          busy,
    output logic                          done,
    output logic                          invalid,
    output logic                          timeout
);

    localparam int DATA_BYTES  = data_width / 8;
    localparam int INSTR_BYTES = instr_width / 8;
    localparam int DELAY_BYTES = 2 * DATA_BYTES;

    typedef enum logic [2:0] {
        IDLE, SEND_CMD, SEND_BLOCK, SEND_REG, SEND_DATA, SEND_INSTR, SEND_DELAY
    } state_t;

    // Frame layout selected at capture time.
    typedef enum logic [2:0] {
        FMT_CMD, FMT_GAIN, FMT_REG, FMT_INSTR, FMT_DELAY
    } fmt_t;

    // Field that follows `cur` in a frame of layout `fmt`; IDLE ends the frame.
    function automatic state_t field_after(state_t cur, fmt_t fmt);
        state_t nxt;
        nxt = IDLE;
        case (fmt)
            FMT_INSTR: if (cur == SEND_CMD) nxt = SEND_BLOCK;
                       else if (cur == SEND_BLOCK) nxt = SEND_INSTR;
            FMT_REG:   if (cur == SEND_CMD) nxt = SEND_BLOCK;
                       else if (cur == SEND_BLOCK) nxt = SEND_REG;
                       else if (cur == SEND_REG) nxt = SEND_DATA;
            FMT_DELAY: if (cur == SEND_CMD) nxt = SEND_DATA;
                       else if (cur == SEND_DATA) nxt = SEND_DELAY;
            FMT_GAIN:  if (cur == SEND_CMD) nxt = SEND_DATA;
            default:   nxt = IDLE;
        endcase
        return nxt;
    endfunction

    state_t                   state_q, state_d;
    fmt_t                     fmt_q, fmt_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [7:0]               block_q, block_d;
    logic [7:0]               regf_q, regf_d;
    logic [data_width-1:0]    data_sr_q, data_sr_d;
    logic [instr_width-1:0]   instr_sr_q, instr_sr_d;
    logic [2*data_width-1:0]  delay_sr_q, delay_sr_d;
    logic [7:0]               out_byte_q, out_byte_d;
    logic                     out_valid_q, out_valid_d;
    logic                     req_ready_q, req_ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     invalid_q, invalid_d;
`ifdef CMD_BYTE_TX_TIMEOUT_EN
    logic [31:0]              wait_q, wait_d;
    logic                     timeout_q, timeout_d;
`else
    localparam int unused_timeout_cycles = timeout_cycles;
`endif

    logic   cmd_known;
    fmt_t   cmd_fmt;
    logic   field_more;
    state_t field_next;

    always_comb begin
        cmd_known = 1'b1;
        cmd_fmt   = FMT_CMD;
        case (req_command)
            `COMMAND_WRITE_BLOCK_INSTR:                          cmd_fmt = FMT_INSTR;
            `COMMAND_WRITE_BLOCK_REG, `COMMAND_UPDATE_BLOCK_REG:  cmd_fmt = FMT_REG;
            `COMMAND_ALLOC_SRAM_DELAY:                           cmd_fmt = FMT_DELAY;
            `COMMAND_SET_INPUT_GAIN, `COMMAND_SET_OUTPUT_GAIN:    cmd_fmt = FMT_GAIN;
            `COMMAND_SWAP_PIPELINES, `COMMAND_RESET_PIPELINE:     cmd_fmt = FMT_CMD;
            default:                                             cmd_known = 1'b0;
        endcase
    end

    // True while the active multi-byte field still has bytes after the current one.
    always_comb begin
        field_more = 1'b0;
        case (state_q)
            SEND_DATA:  field_more = (cnt_q != 8'(DATA_BYTES - 1));
            SEND_INSTR: field_more = (cnt_q != 8'(INSTR_BYTES - 1));
            SEND_DELAY: field_more = (cnt_q != 8'(DELAY_BYTES - 1));
            default:    field_more = 1'b0;
        endcase
        field_next = field_after(state_q, fmt_q);
    end

    always_comb begin
        // NOTE: every _d starts as its _q (pulses as 0) so no path leaves a latch.
        state_d     = state_q;
        fmt_d       = fmt_q;
        cnt_d       = cnt_q;
        block_d     = block_q;
        regf_d      = regf_q;
        data_sr_d   = data_sr_q;
        instr_sr_d  = instr_sr_q;
        delay_sr_d  = delay_sr_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        invalid_d   = 1'b0;
`ifdef CMD_BYTE_TX_TIMEOUT_EN
        wait_d      = wait_q;
        timeout_d   = 1'b0;
`endif
        if (state_q == IDLE) begin
            if (req_valid) begin
                if (cmd_known) begin
                    state_d     = SEND_CMD;
                    fmt_d       = cmd_fmt;
                    cnt_d       = 8'd0;
                    block_d     = 8'(req_block);
                    regf_d      = 8'(req_reg);
                    data_sr_d   = req_data;
                    instr_sr_d  = req_instr;
                    delay_sr_d  = req_delay;
                    out_byte_d  = req_command;
                    out_valid_d = 1'b1;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
`ifdef CMD_BYTE_TX_TIMEOUT_EN
                    wait_d      = 32'd0;
`endif
                end else begin
                    invalid_d = 1'b1;
                end
            end
        end else if (next && out_valid_q) begin
`ifdef CMD_BYTE_TX_TIMEOUT_EN
            wait_d = 32'd0;
`endif
            if (field_more) begin
                // Stay in the field: shift its next byte into the top position.
                cnt_d = cnt_q + 8'd1;
                case (state_q)
                    SEND_DATA: begin
                        data_sr_d  = data_sr_q << 8;
                        out_byte_d = data_sr_d[data_width-1 -: 8];
                    end
                    SEND_INSTR: begin
                        instr_sr_d = instr_sr_q << 8;
                        out_byte_d = instr_sr_d[instr_width-1 -: 8];
                    end
                    default: begin
                        delay_sr_d = delay_sr_q << 8;
                        out_byte_d = delay_sr_d[2*data_width-1 -: 8];
                    end
                endcase
            end else begin
                cnt_d   = 8'd0;
                state_d = field_next;
                case (field_next)
                    SEND_BLOCK: out_byte_d = block_q;
                    SEND_REG:   out_byte_d = regf_q;
                    SEND_DATA:  out_byte_d = data_sr_q[data_width-1 -: 8];
                    SEND_INSTR: out_byte_d = instr_sr_q[instr_width-1 -: 8];
                    SEND_DELAY: out_byte_d = delay_sr_q[2*data_width-1 -: 8];
                    default: begin
                        out_byte_d  = 8'd0;
                        out_valid_d = 1'b0;
                        req_ready_d = 1'b1;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                endcase
            end
        end
`ifdef CMD_BYTE_TX_TIMEOUT_EN
        else if (wait_q == 32'(timeout_cycles - 1)) begin
            // Consumer stalled too long: drop the frame without a done pulse.
            state_d     = IDLE;
            cnt_d       = 8'd0;
            wait_d      = 32'd0;
            out_byte_d  = 8'd0;
            out_valid_d = 1'b0;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
            timeout_d   = 1'b1;
        end else begin
            wait_d = wait_q + 32'd1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only; the shift
    // registers are reset as well so a dropped frame leaves no stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            fmt_q       <= FMT_CMD;
            cnt_q       <= 8'd0;
            block_q     <= 8'd0;
            regf_q      <= 8'd0;
            data_sr_q   <= '0;
            instr_sr_q  <= '0;
            delay_sr_q  <= '0;
            out_byte_q  <= 8'd0;
            out_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            invalid_q   <= 1'b0;
`ifdef CMD_BYTE_TX_TIMEOUT_EN
            wait_q      <= 32'd0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fmt_q       <= fmt_d;
            cnt_q       <= cnt_d;
            block_q     <= block_d;
            regf_q      <= regf_d;
            data_sr_q   <= data_sr_d;
            instr_sr_q  <= instr_sr_d;
            delay_sr_q  <= delay_sr_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            invalid_q   <= invalid_d;
`ifdef CMD_BYTE_TX_TIMEOUT_EN
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign invalid   = invalid_q;
`ifdef CMD_BYTE_TX_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_byte_tx.sv
// Self-checking bench for cmd_byte_tx: a table of directed frames, hand-written
// sequences for back-to-back, unknown command, stall and mid-frame reset, and
// randomized frames checked against a byte-list model of the frame layouts.
`timescale 1ns/1ps

`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 32
`endif
`ifndef BLOCK_REG_ADDR_WIDTH
`define BLOCK_REG_ADDR_WIDTH 4
`endif
`ifndef COMMAND_WRITE_BLOCK_INSTR
`define COMMAND_WRITE_BLOCK_INSTR 8'h01
`endif
`ifndef COMMAND_WRITE_BLOCK_REG
`define COMMAND_WRITE_BLOCK_REG 8'h02
`endif
`ifndef COMMAND_UPDATE_BLOCK_REG
`define COMMAND_UPDATE_BLOCK_REG 8'h03
`endif
`ifndef COMMAND_ALLOC_SRAM_DELAY
`define COMMAND_ALLOC_SRAM_DELAY 8'h04
`endif
`ifndef COMMAND_SET_INPUT_GAIN
`define COMMAND_SET_INPUT_GAIN 8'h05
`endif
`ifndef COMMAND_SET_OUTPUT_GAIN
`define COMMAND_SET_OUTPUT_GAIN 8'h06
`endif
`ifndef COMMAND_SWAP_PIPELINES
`define COMMAND_SWAP_PIPELINES 8'h07
`endif
`ifndef COMMAND_RESET_PIPELINE
`define COMMAND_RESET_PIPELINE 8'h08
`endif

module tb_cmd_byte_tx;

    localparam int NB = 32;
    localparam int DW = 16;
    localparam int IW = `BLOCK_INSTR_WIDTH;
    localparam int RW = `BLOCK_REG_ADDR_WIDTH;
    localparam int BW = $clog2(NB);

    logic            clk = 1'b0;
    logic            reset_n;
    logic            req_valid;
    logic            req_ready;
    logic [7:0]      req_command;
    logic [BW-1:0]   req_block;
    logic [RW-1:0]   req_reg;
    logic [DW-1:0]   req_data;
    logic [IW-1:0]   req_instr;
    logic [2*DW-1:0] req_delay;
    logic [7:0]      out_byte;
    logic            out_valid;
    logic            next;
    logic            busy;
    logic            done;
    logic            invalid;
    logic            timeout;

    cmd_byte_tx #(
        .n_blocks(NB), .data_width(DW), .instr_width(IW), .timeout_cycles(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_command(req_command),
        .req_block(req_block), .req_reg(req_reg), .req_data(req_data),
        .req_instr(req_instr), .req_delay(req_delay),
        .out_byte(out_byte), .out_valid(out_valid), .next(next),
        .busy(busy), .done(done), .invalid(invalid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]      cmd;
        logic [BW-1:0]   blk;
        logic [RW-1:0]   rg;
        logic [DW-1:0]   data;
        logic [IW-1:0]   instr;
        logic [2*DW-1:0] delay;
        bit              known;
        int              n_tail;   // bytes after the command byte
        logic [63:0]     tail;     // those bytes, first one most significant
    } vec_t;

    function automatic vec_t mk(logic [7:0] cmd, int blk, int rg, logic [63:0] data,
                                logic [63:0] instr, logic [63:0] delay,
                                bit known, int n_tail, logic [63:0] tail);
        vec_t v;
        v.cmd = cmd; v.blk = BW'(blk); v.rg = RW'(rg); v.data = DW'(data);
        v.instr = IW'(instr); v.delay = (2*DW)'(delay);
        v.known = known; v.n_tail = n_tail; v.tail = tail;
        return v;
    endfunction

    // Reference model: the frame as a list of bytes, built from the layout rules.
    function automatic void push_field(logic [63:0] val, int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) exp_q.push_back(8'((val >> (8 * i)) & 64'hFF));
    endfunction

    function automatic bit model_frame(logic [7:0] cmd, logic [BW-1:0] blk, logic [RW-1:0] rg,
                                       logic [DW-1:0] data, logic [IW-1:0] instr,
                                       logic [2*DW-1:0] delay);
        exp_q.delete();
        case (cmd)
            `COMMAND_WRITE_BLOCK_INSTR: begin
                push_field(64'(cmd), 1); push_field(64'(blk), 1); push_field(64'(instr), IW / 8);
            end
            `COMMAND_WRITE_BLOCK_REG, `COMMAND_UPDATE_BLOCK_REG: begin
                push_field(64'(cmd), 1); push_field(64'(blk), 1); push_field(64'(rg), 1);
                push_field(64'(data), DW / 8);
            end
            `COMMAND_ALLOC_SRAM_DELAY: begin
                push_field(64'(cmd), 1); push_field(64'(data), DW / 8); push_field(64'(delay), DW / 4);
            end
            `COMMAND_SET_INPUT_GAIN, `COMMAND_SET_OUTPUT_GAIN: begin
                push_field(64'(cmd), 1); push_field(64'(data), DW / 8);
            end
            `COMMAND_SWAP_PIPELINES, `COMMAND_RESET_PIPELINE: push_field(64'(cmd), 1);
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // Called on a falling edge; returns on the falling edge after the capture edge.
    task automatic send_req(input logic [7:0] cmd, input logic [BW-1:0] blk, input logic [RW-1:0] rg,
                            input logic [DW-1:0] data, input logic [IW-1:0] instr,
                            input logic [2*DW-1:0] delay);
        req_command = cmd; req_block = blk; req_reg = rg;
        req_data = data; req_instr = instr; req_delay = delay;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_command = 8'($urandom); req_data = DW'($urandom);
    endtask

    // Consumes the frame in exp_q (byte 0 already visible), random gaps before each next.
    task automatic expect_frame(input string tag, input bit known, input int gapmax);
        if (!known) begin
            check({tag, " invalid"}, 64'(invalid), 64'd1);
            check({tag, " inv busy"}, 64'(busy), 64'd0);
            check({tag, " inv ready"}, 64'(req_ready), 64'd1);
            check({tag, " inv valid"}, 64'(out_valid), 64'd0);
            @(negedge clk);
            check({tag, " invalid pulse"}, 64'(invalid), 64'd0);
            check({tag, " inv valid2"}, 64'(out_valid), 64'd0);
            return;
        end
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " ready low"}, 64'(req_ready), 64'd0);
        foreach (exp_q[i]) begin
            int gap = $urandom_range(gapmax, 0);
            for (int g = 0; g < gap; g++) begin
                check($sformatf("%s hold b%0d", tag, i), 64'(out_byte), 64'(exp_q[i]));
                req_valid = 1'($urandom); req_command = 8'($urandom); req_block = BW'($urandom);
                @(negedge clk);
            end
            check($sformatf("%s b%0d", tag, i), 64'(out_byte), 64'(exp_q[i]));
            check($sformatf("%s valid b%0d", tag, i), 64'(out_valid), 64'd1);
            req_valid = 1'b0;
            next = 1'b1;
            @(negedge clk);
            next = 1'b0;
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " end valid"}, 64'(out_valid), 64'd0);
        check({tag, " end busy"}, 64'(busy), 64'd0);
        check({tag, " end ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        check({tag, " done pulse"}, 64'(done), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = mk(`COMMAND_WRITE_BLOCK_REG,  5,  3, 64'hBEEF, 64'h0, 64'h0, 1'b1, 4, 64'h0503_BEEF);
        vecs[1] = mk(`COMMAND_ALLOC_SRAM_DELAY, 9,  1, 64'h0010, 64'h0, 64'h0001_2345, 1'b1, 6, 64'h0010_0001_2345);
        vecs[2] = mk(`COMMAND_WRITE_BLOCK_INSTR, 7, 2, 64'h1111, 64'hDEAD_BEEF, 64'h0, 1'b1, 5, 64'h07_DEAD_BEEF);
        vecs[3] = mk(`COMMAND_UPDATE_BLOCK_REG, 31, 15, 64'h00FF, 64'h0, 64'h0, 1'b1, 4, 64'h1F0F_00FF);
        vecs[4] = mk(`COMMAND_SET_INPUT_GAIN,   12,  4, 64'h1234, 64'h0, 64'h0, 1'b1, 2, 64'h1234);
        vecs[5] = mk(`COMMAND_SET_OUTPUT_GAIN,   0,  0, 64'hABCD, 64'h0, 64'h0, 1'b1, 2, 64'hABCD);
        vecs[6] = mk(`COMMAND_SWAP_PIPELINES,    3,  3, 64'h5555, 64'h0, 64'h0, 1'b1, 0, 64'h0);
        vecs[7] = mk(`COMMAND_RESET_PIPELINE,    1,  1, 64'h7777, 64'h0, 64'h0, 1'b1, 0, 64'h0);
        vecs[8] = mk(8'hFF,                      2,  2, 64'h9999, 64'h0, 64'h0, 1'b0, 0, 64'h0);

        reset_n = 1'b0; req_valid = 1'b0; next = 1'b0;
        req_command = 8'h0; req_block = '0; req_reg = '0;
        req_data = '0; req_instr = '0; req_delay = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_byte", 64'(out_byte), 64'd0);
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst invalid", 64'(invalid), 64'd0);
        check("rst timeout", 64'(timeout), 64'd0);

        // Directed table.
        foreach (vecs[v]) begin
            exp_q.delete();
            if (vecs[v].known) begin
                exp_q.push_back(vecs[v].cmd);
                for (int i = vecs[v].n_tail - 1; i >= 0; i--) exp_q.push_back(8'(vecs[v].tail >> (8 * i)));
            end
            send_req(vecs[v].cmd, vecs[v].blk, vecs[v].rg, vecs[v].data, vecs[v].instr, vecs[v].delay);
            expect_frame($sformatf("vec%0d", v), vecs[v].known, (v == 0) ? 0 : 2);
        end

        // Back-to-back: swap, second request already held on req_valid.
        req_command = `COMMAND_SWAP_PIPELINES; req_valid = 1'b1;
        @(negedge clk);
        req_command = `COMMAND_SET_INPUT_GAIN; req_data = 16'hA55A;
        check("b2b first byte", 64'(out_byte), 64'(`COMMAND_SWAP_PIPELINES));
        check("b2b ready low", 64'(req_ready), 64'd0);
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        check("b2b done", 64'(done), 64'd1);
        check("b2b gap valid", 64'(out_valid), 64'd0);
        check("b2b ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b second cmd", 64'(out_byte), 64'(`COMMAND_SET_INPUT_GAIN));
        check("b2b second valid", 64'(out_valid), 64'd1);
        exp_q.delete();
        exp_q.push_back(`COMMAND_SET_INPUT_GAIN); exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        expect_frame("b2b", 1'b1, 1);

        // Stalled consumer on an instruction frame.
        send_req(`COMMAND_WRITE_BLOCK_INSTR, BW'(4), RW'(0), DW'(0), IW'(64'hCAFE_F00D), '0);
        for (int k = 1; k <= 20; k++) begin
`ifdef CMD_BYTE_TX_TIMEOUT_EN
            if (k < 9) begin
                check($sformatf("stall valid %0d", k), 64'(out_valid), 64'd1);
                check($sformatf("stall byte %0d", k), 64'(out_byte), 64'(`COMMAND_WRITE_BLOCK_INSTR));
                check($sformatf("stall tmo %0d", k), 64'(timeout), 64'd0);
            end else begin
                check($sformatf("abort tmo %0d", k), 64'(timeout), 64'(k == 9));
                check($sformatf("abort valid %0d", k), 64'(out_valid), 64'd0);
                check($sformatf("abort ready %0d", k), 64'(req_ready), 64'd1);
                check($sformatf("abort done %0d", k), 64'(done), 64'd0);
            end
`else
            check($sformatf("stall valid %0d", k), 64'(out_valid), 64'd1);
            check($sformatf("stall byte %0d", k), 64'(out_byte), 64'(`COMMAND_WRITE_BLOCK_INSTR));
            check($sformatf("stall tmo %0d", k), 64'(timeout), 64'd0);
`endif
            @(negedge clk);
        end
`ifndef CMD_BYTE_TX_TIMEOUT_EN
        void'(model_frame(`COMMAND_WRITE_BLOCK_INSTR, BW'(4), RW'(0), DW'(0), IW'(64'hCAFE_F00D), '0));
        expect_frame("stall", 1'b1, 0);
`endif

        // Reset after the second byte of an alloc frame.
        send_req(`COMMAND_ALLOC_SRAM_DELAY, '0, '0, DW'(16'h8421), '0, (2*DW)'(32'h1234_5678));
        for (int b = 0; b < 2; b++) begin
            next = 1'b1;
            @(negedge clk);
            next = 1'b0;
        end
        check("pre-rst byte", 64'(out_byte), 64'h21);
        #2 reset_n = 1'b0;
        #1;
        check("async rst valid", 64'(out_valid), 64'd0);
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst byte", 64'(out_byte), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post-rst ready", 64'(req_ready), 64'd1);
        check("post-rst valid", 64'(out_valid), 64'd0);
        check("post-rst done", 64'(done), 64'd0);
        // A stray next while idle is ignored.
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        check("idle next valid", 64'(out_valid), 64'd0);
        check("idle next done", 64'(done), 64'd0);
        check("idle next busy", 64'(busy), 64'd0);

        // Randomized frames against the model.
        for (int r = 0; r < 200; r++) begin
            logic [7:0]      cmd;
            logic [BW-1:0]   blk;
            logic [RW-1:0]   rg;
            logic [DW-1:0]   data;
            logic [IW-1:0]   instr;
            logic [2*DW-1:0] delay;
            bit              known;
            logic [7:0]      cmds [8];
            cmds = '{`COMMAND_WRITE_BLOCK_INSTR, `COMMAND_WRITE_BLOCK_REG, `COMMAND_UPDATE_BLOCK_REG,
                     `COMMAND_ALLOC_SRAM_DELAY, `COMMAND_SET_INPUT_GAIN, `COMMAND_SET_OUTPUT_GAIN,
                     `COMMAND_SWAP_PIPELINES, `COMMAND_RESET_PIPELINE};
            cmd   = ($urandom_range(9, 0) == 0) ? 8'($urandom) : cmds[$urandom_range(7, 0)];
            blk   = BW'($urandom);
            rg    = RW'($urandom);
            data  = DW'($urandom);
            instr = IW'({$urandom, $urandom});
            delay = (2*DW)'({$urandom, $urandom});
            known = model_frame(cmd, blk, rg, data, instr, delay);
            send_req(cmd, blk, rg, data, instr, delay);
            expect_frame($sformatf("rnd%0d", r), known, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
